conv_output_packer: RTL and testbench

// Downstream stage of the 3x3 conv MAC engine. Captures each final 32-bit signed accumulator value
// and adds a per-channel bias. Then applies a rounding arithmetic right shift, optional ReLU and

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_out_fifo.sv | 53 +++++
 rtl/conv_output_packer.sv | 129 ++++++++++++
 tb/tb_conv_output_packer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and int8 saturation helper for the conv output packer
package conv_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_W   = 8;
    localparam int LANES    = 4;
    localparam int CNT_W    = 2;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    function automatic logic [BYTE_W-1:0] sat_int8(input logic signed [33:0] v,
                                                   input logic              relu);
        logic signed [33:0] t;
        t = (relu && (v < 0)) ? '0 : v;
        if (t > $signed(34'(INT8_MAX)))
            return 8'h7F;
        else if (t < $signed(34'(INT8_MIN)))
            return 8'h80;
        else
            return t[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// rtl/conv_out_fifo.sv - first-word-fall-through sync FIFO for packed output words
module conv_out_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop_eff  = pop && !empty;
    // A full FIFO still takes a word when the same cycle pops one
    assign push_eff = push && (!full || pop_eff);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_eff)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_eff)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_eff && !pop_eff)
                level <= level + 1'b1;
            else if (pop_eff && !push_eff)
                level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/conv_output_packer.sv
// rtl/conv_output_packer.sv - bias add, rounding requant, ReLU/int8 saturation and 4-lane word packing
module conv_output_packer
    import conv_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                acc_result,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [31:0]                bias,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       relu_en,
    input  logic                       flush,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                       accept;
    logic                       s1_valid;
    logic signed [32:0]         s1_sum;
    logic [SHIFT_W-1:0]         s1_shift;
    logic                       s1_relu;
    logic                       s2_valid;
    logic [BYTE_W-1:0]          s2_byte;
    logic signed [33:0]         req_ext;
    logic signed [33:0]         req_rnd;
    logic signed [33:0]         req_val;
    logic [CNT_W-1:0]           cnt;
    logic [3*BYTE_W-1:0]        partial;
    logic                       flush_pending;
    logic                       flush_done;
    logic                       lane_full;
    logic                       word_push;
    logic [WORD_W-1:0]          word_data;
    logic                       fifo_full;
    logic                       fifo_empty;

    // Two free slots cover the bytes still in S1/S2 when ready drops
    assign acc_ready = !flush_pending && (fifo_level <= LVL_W'(DEPTH - 2));
    assign accept    = acc_valid && acc_ready;
    assign out_valid = !fifo_empty;

    always_comb begin
        req_ext = {s1_sum[32], s1_sum};
        req_rnd = '0;
        req_val = req_ext;
        if (s1_shift != '0) begin
            req_rnd = 34'sd1 <<< (s1_shift - 1'b1);
            req_val = (req_ext + req_rnd) >>> s1_shift;
        end
    end

    assign flush_done = flush_pending && !s1_valid && !s2_valid
                        && (fifo_level < LVL_W'(DEPTH));
    assign lane_full  = s2_valid && (cnt == 2'd3);
    assign word_push  = lane_full || (flush_done && (cnt != '0));
    // Unused upper lanes of a flushed word are already zero in partial
    assign word_data  = lane_full ? {s2_byte, partial} : {8'h00, partial};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sum        <= '0;
            s1_shift      <= '0;
            s1_relu       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_byte       <= '0;
            cnt           <= '0;
            partial       <= '0;
            flush_pending <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= {acc_result[31], acc_result} + {bias[31], bias};
                s1_shift <= shift;
                s1_relu  <= relu_en;
            end

            s2_valid <= s1_valid;
            if (s1_valid)
                s2_byte <= sat_int8(req_val, s1_relu);

            if (s2_valid) begin
                if (cnt == 2'd3) begin
                    partial <= '0;
                    cnt     <= '0;
                end else begin
                    partial[{cnt, 3'b000} +: BYTE_W] <= s2_byte;
                    cnt <= cnt + 1'b1;
                end
            end else if (flush_done) begin
                partial <= '0;
                cnt     <= '0;
            end

            if (flush_done)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;

            if (word_push && fifo_full && !out_ready)
                overflow <= 1'b1;
        end
    end

    conv_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (word_push),
        .push_data (word_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_conv_output_packer.sv
// tb/tb_conv_output_packer.sv - directed self-checking bench for conv_output_packer
module tb_conv_output_packer;
    localparam int DEPTH   = 8;
    localparam int SHIFT_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        acc_result;
    logic               acc_valid;
    logic               acc_ready;
    logic [31:0]        bias;
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
    logic               flush;
    logic [31:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         fifo_level;
    logic               overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_output_packer #(.DEPTH(DEPTH), .SHIFT_W(SHIFT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_result (acc_result),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .bias       (bias),
        .shift      (shift),
        .relu_en    (relu_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input int val, input int b, input int sh, input logic relu);
        int guard;
        @(negedge clk);
        acc_valid  = 1'b1;
        acc_result = val;
        bias       = b;
        shift      = SHIFT_W'(sh);
        relu_en    = relu;
        guard      = 0;
        while (!acc_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_ready_timeout", 32'(acc_ready), 32'd1);
        @(posedge clk);
        #1 acc_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
        check(tag, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int          nacc;
        logic [31:0] w;
        int          idx;

        rst = 1'b1; acc_result = '0; acc_valid = 1'b0; bias = '0; shift = '0;
        relu_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc_ready", 32'(acc_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // 1) basic packing and latency
        send(1, 0, 0, 0); send(2, 0, 0, 0); send(3, 0, 0, 0); send(4, 0, 0, 0);
        @(negedge clk); check("t1_lat_t1", 32'(out_valid), 32'd0);
        @(negedge clk); check("t1_lat_t2", 32'(out_valid), 32'd0);
        @(negedge clk); check("t1_lat_t3", 32'(out_valid), 32'd1);
        check("t1_level", 32'(fifo_level), 32'd1);
        expect_word("t1_word", 32'h04030201);

        // 2) bias, rounding shift
        send(1000, -10, 4, 0); send(-1000, -10, 4, 0); send(40, 0, 0, 0); send(-40, 0, 0, 0);
        expect_word("t2_word", 32'hD828C13E);

        // 3) saturation and ReLU
        send(70000, 0, 0, 0); send(-70000, 0, 0, 0); send(-5, 0, 0, 1); send(300, 0, 0, 1);
        expect_word("t3_word", 32'h7F00807F);

        // 4) flush partial word, then flush with nothing pending
        send(5, 0, 0, 0); send(6, 0, 0, 0);
        pulse_flush();
        expect_word("t4_word", 32'h00000605);
        pulse_flush();
        repeat (6) @(negedge clk);
        check("t4_noword_valid", 32'(out_valid), 32'd0);
        check("t4_noword_level", 32'(fifo_level), 32'd0);
        check("t4_ready_back", 32'(acc_ready), 32'd1);

        // 5) backpressure
        nacc = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            acc_valid = 1'b1; acc_result = nacc; bias = '0; shift = '0; relu_en = 1'b0;
            if (acc_ready) nacc++;
        end
        @(negedge clk);
        acc_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_level_stall", 32'(fifo_level), 32'(DEPTH - 1));
        check("t5_ready_low", 32'(acc_ready), 32'd0);
        check("t5_accepted", 32'(nacc), 32'd30);
        pulse_flush();
        repeat (5) @(negedge clk);
        check("t5_level_full", 32'(fifo_level), 32'(DEPTH));
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_ready_full", 32'(acc_ready), 32'd0);
        for (int wi = 0; wi < DEPTH; wi++) begin
            for (int l = 0; l < 4; l++) begin
                idx = 4 * wi + l;
                w[8*l +: 8] = (idx < nacc) ? 8'(idx) : 8'h00;
            end
            expect_word($sformatf("t5_word%0d", wi), w);
        end
        @(negedge clk);
        check("t5_drained", 32'(fifo_level), 32'd0);
        check("t5_ready_after", 32'(acc_ready), 32'd1);
        check("t5_overflow_after", 32'(overflow), 32'd0);

        // 6) reset mid-word discards everything in flight
        send(7, 0, 0, 0); send(8, 0, 0, 0); send(9, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_output", 32'(out_valid), 32'd0);
        send(9, 0, 0, 0); send(10, 0, 0, 0); send(11, 0, 0, 0); send(12, 0, 0, 0);
        expect_word("t6_word", 32'h0C0B0A09);
        repeat (4) @(negedge clk);
        check("t6_single_word", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
